// File: rtl/video_pkg.sv
// Shared types for the video timing transmitter: pixel, coordinate,
// timing-region and controller-state definitions.
package video_pkg;

    typedef logic [23:0] rgb_t;
    typedef logic [11:0] coord_t;

    localparam int COORD_RANGE = 4096;

    typedef enum logic [1:0] {
        R_ACTIVE = 2'd0,
        R_FP     = 2'd1,
        R_SYNC   = 2'd2,
        R_BP     = 2'd3
    } region_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/timing_counter.sv
// One axis of the raster: counts 0..TOTAL-1 on inc_i, reports the region
// the current count falls in and flags the wrap back to 0.
module timing_counter
    import video_pkg::*;
#(
    parameter int ACTIVE = 1280,
    parameter int FP     = 110,
    parameter int SYNC   = 40,
    parameter int BP     = 220
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    clr_i,
    input  logic    inc_i,
    output coord_t  count_o,
    output region_e region_o,
    output logic    wrap_o
);

    localparam int     TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam coord_t FP_START   = coord_t'(ACTIVE);
    localparam coord_t SYNC_START = coord_t'(ACTIVE + FP);
    localparam coord_t BP_START   = coord_t'(ACTIVE + FP + SYNC);
    localparam coord_t LAST       = coord_t'(TOTAL - 1);

    coord_t count_q, count_d;

    assign wrap_o  = inc_i && (count_q == LAST);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = wrap_o ? '0 : count_q + 12'd1;
        end
    end

    always_comb begin
        region_o = R_ACTIVE;
        if (count_q >= BP_START) begin
            region_o = R_BP;
        end else if (count_q >= SYNC_START) begin
            region_o = R_SYNC;
        end else if (count_q >= FP_START) begin
            region_o = R_FP;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/video_timing_tx.sv
// Raster timing generator that pulls pixels from a ready/valid source and
// emits registered RGB, data-valid, syncs and coordinates.
//
//   state | meaning
//   IDLE  | counters held at 0, outputs inactive
//   RUN   | raster running, en_i high
//   DRAIN | en_i dropped, finishing the current frame
module video_timing_tx
    import video_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en_i,
    input  rgb_t   rgb_i,
    input  logic   rgb_valid_i,
    output logic   rgb_ready_o,
    output rgb_t   rgb_o,
    output logic   dv_o,
    output logic   hs_o,
    output logic   vs_o,
    output coord_t x_o,
    output coord_t y_o,
    output logic   frame_start_o,
    output logic   underflow_o,
    input  logic   underflow_clr_i
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > COORD_RANGE || V_TOTAL > COORD_RANGE) begin : g_size_chk
        $error("video_timing_tx: H_TOTAL/V_TOTAL exceed 12-bit counter range");
    end

    state_e  state_q, state_d;
    coord_t  h_cnt, v_cnt;
    region_e h_region, v_region;
    logic    h_wrap, v_wrap;
    logic    running, pix_act;

    assign running = (state_q != IDLE);

    timing_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (!running),
        .inc_i    (running),
        .count_o  (h_cnt),
        .region_o (h_region),
        .wrap_o   (h_wrap)
    );

    timing_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (!running),
        .inc_i    (h_wrap),
        .count_o  (v_cnt),
        .region_o (v_region),
        .wrap_o   (v_wrap)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en_i) state_d = RUN;
            RUN:     if (!en_i) state_d = DRAIN;
            DRAIN: begin
                // a re-enable takes priority over the end-of-frame stop
                if (en_i) begin
                    state_d = RUN;
                end else if (v_wrap) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pix_act     = running && (h_region == R_ACTIVE) && (v_region == R_ACTIVE);
    assign rgb_ready_o = pix_act;

    rgb_t   rgb_d, rgb_q;
    coord_t x_d, x_q, y_d, y_q;
    logic   dv_d, dv_q, hs_d, hs_q, vs_d, vs_q, fs_d, fs_q, uf_d, uf_q;

    always_comb begin
        dv_d = pix_act;
        rgb_d = (pix_act && rgb_valid_i) ? rgb_i : '0;
        hs_d = (running && h_region == R_SYNC) ? HS_POL : ~HS_POL;
        vs_d = (running && v_region == R_SYNC) ? VS_POL : ~VS_POL;
        x_d  = pix_act ? h_cnt : '0;
        y_d  = pix_act ? v_cnt : '0;
        fs_d = pix_act && (h_cnt == '0) && (v_cnt == '0);
        uf_d = uf_q;
        if (pix_act && !rgb_valid_i) begin
            uf_d = 1'b1;
        end else if (underflow_clr_i) begin
            uf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dv_q    <= 1'b0;
            rgb_q   <= '0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            x_q     <= '0;
            y_q     <= '0;
            fs_q    <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dv_q    <= dv_d;
            rgb_q   <= rgb_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fs_q    <= fs_d;
            uf_q    <= uf_d;
        end
    end

    assign dv_o          = dv_q;
    assign rgb_o         = rgb_q;
    assign hs_o          = hs_q;
    assign vs_o          = vs_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign frame_start_o = fs_q;
    assign underflow_o   = uf_q;

endmodule

// File: tb/tb_video_timing_tx.sv
// Bench for video_timing_tx on an 8x6 raster: a reference model pushes the
// expected registered outputs into a scoreboard each cycle, popped after the edge.
module tb_video_timing_tx;
    import video_pkg::*;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    logic   en_i = 1'b0;
    rgb_t   rgb_i = '0;
    logic   rgb_valid_i = 1'b1;
    logic   underflow_clr_i = 1'b0;

    logic   rgb_ready_o, dv_o, hs_o, vs_o, frame_start_o, underflow_o;
    rgb_t   rgb_o;
    coord_t x_o, y_o;

    logic   rgb_ready_b, dv_b, hs_b, vs_b, fs_b, uf_b;
    rgb_t   rgb_b;
    coord_t x_b, y_b;

    video_timing_tx #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .rgb_i(rgb_i), .rgb_valid_i(rgb_valid_i),
        .rgb_ready_o(rgb_ready_o), .rgb_o(rgb_o), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
        .x_o(x_o), .y_o(y_o), .frame_start_o(frame_start_o), .underflow_o(underflow_o),
        .underflow_clr_i(underflow_clr_i)
    );

    video_timing_tx #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_neg (
        .clk(clk), .rst(rst), .en_i(en_i), .rgb_i(rgb_i), .rgb_valid_i(rgb_valid_i),
        .rgb_ready_o(rgb_ready_b), .rgb_o(rgb_b), .dv_o(dv_b), .hs_o(hs_b), .vs_o(vs_b),
        .x_o(x_b), .y_o(y_b), .frame_start_o(fs_b), .underflow_o(uf_b),
        .underflow_clr_i(underflow_clr_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dv;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        int          x;
        int          y;
        logic        fs;
        logic        uf;
    } exp_t;

    exp_t sb[$];

    int       checks = 0;
    int       failures = 0;
    int       m_state = 0;
    int       m_h = 0;
    int       m_v = 0;
    logic     m_uf = 1'b0;
    logic [23:0] src_data = 24'h100000;
    bit       starve_on = 1'b0;
    int       starve_h = 0;
    int       starve_v = 0;
    bit       period_en = 1'b0;
    longint   cyc = 0;
    longint   last_fs = -1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string ph);
        chk({ph, "_dv"},    32'(dv_o), 32'(0));
        chk({ph, "_fs"},    32'(frame_start_o), 32'(0));
        chk({ph, "_uf"},    32'(underflow_o), 32'(0));
        chk({ph, "_rgb"},   32'(rgb_o), 32'(0));
        chk({ph, "_x"},     32'(x_o), 32'(0));
        chk({ph, "_y"},     32'(y_o), 32'(0));
        chk({ph, "_hs"},    32'(hs_o), 32'(0));
        chk({ph, "_vs"},    32'(vs_o), 32'(0));
        chk({ph, "_hsneg"}, 32'(hs_b), 32'(1));
        chk({ph, "_vsneg"}, 32'(vs_b), 32'(1));
        chk({ph, "_ready"}, 32'(rgb_ready_o), 32'(0));
    endtask

    // One pixel clock: predict, push, advance the model, clock, pop and compare.
    task automatic cycle();
        exp_t e, got;
        logic act, frame_end;
        rgb_valid_i = (starve_on && m_state != 0 && m_h == starve_h && m_v == starve_v) ? 1'b0 : 1'b1;
        rgb_i = src_data;
        #1;
        act = (m_state != 0) && (m_h < 4) && (m_v < 3);
        chk("ready", 32'(rgb_ready_o), 32'(act));
        e.dv  = act;
        e.rgb = (act && rgb_valid_i) ? src_data : 24'h0;
        e.hs  = (m_state != 0) && (m_h == 5 || m_h == 6);
        e.vs  = (m_state != 0) && (m_v == 4);
        e.x   = act ? m_h : 0;
        e.y   = act ? m_v : 0;
        e.fs  = act && m_h == 0 && m_v == 0;
        e.uf  = (act && !rgb_valid_i) ? 1'b1 : (underflow_clr_i ? 1'b0 : m_uf);
        sb.push_back(e);
        m_uf = e.uf;
        if (act && rgb_valid_i) src_data = src_data + 24'h1;

        frame_end = (m_h == 7) && (m_v == 5);
        if (m_state == 0) begin
            m_h = 0;
            m_v = 0;
        end else if (m_h == 7) begin
            m_h = 0;
            m_v = (m_v == 5) ? 0 : m_v + 1;
        end else begin
            m_h = m_h + 1;
        end
        case (m_state)
            0: if (en_i) m_state = 1;
            1: if (!en_i) m_state = 2;
            default: begin
                if (en_i) m_state = 1;
                else if (frame_end) m_state = 0;
            end
        endcase

        @(posedge clk);
        #1;
        cyc++;
        got = sb.pop_front();
        chk("dv",    32'(dv_o), 32'(got.dv));
        chk("rgb",   32'(rgb_o), 32'(got.rgb));
        chk("hs",    32'(hs_o), 32'(got.hs));
        chk("vs",    32'(vs_o), 32'(got.vs));
        chk("hsneg", 32'(hs_b), 32'(!got.hs));
        chk("vsneg", 32'(vs_b), 32'(!got.vs));
        chk("x",     32'(x_o), 32'(got.x));
        chk("y",     32'(y_o), 32'(got.y));
        chk("fs",    32'(frame_start_o), 32'(got.fs));
        chk("uf",    32'(underflow_o), 32'(got.uf));
        if (period_en && frame_start_o) begin
            if (last_fs >= 0) chk("fs_period", 32'(cyc - last_fs), 32'(48));
            last_fs = cyc;
        end
    endtask

    task automatic run_until(input string tag, input int hh, input int vv);
        for (int i = 0; i < 60 && !(m_state != 0 && m_h == hh && m_v == vv); i++) cycle();
        chk(tag, 32'(m_state != 0 && m_h == hh && m_v == vv), 32'(1));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("por");
        rst = 1'b1;
        repeat (3) cycle();

        // continuous run, two full frames
        en_i = 1'b1;
        period_en = 1'b1;
        repeat (100) cycle();

        // single starved pixel, then clear
        starve_on = 1'b1; starve_h = 2; starve_v = 0;
        run_until("reach_starve", 2, 0);
        cycle();
        starve_on = 1'b0;
        repeat (5) cycle();
        underflow_clr_i = 1'b1;
        cycle();
        underflow_clr_i = 1'b0;
        repeat (4) cycle();

        // clear coinciding with a starved pixel: set must win
        starve_on = 1'b1;
        run_until("reach_starve2", 2, 0);
        underflow_clr_i = 1'b1;
        cycle();
        underflow_clr_i = 1'b0;
        starve_on = 1'b0;
        repeat (3) cycle();
        underflow_clr_i = 1'b1;
        cycle();
        underflow_clr_i = 1'b0;
        period_en = 1'b0;

        // drop then re-raise enable within the frame
        run_until("reach_y1a", 0, 1);
        en_i = 1'b0;
        repeat (8) cycle();
        en_i = 1'b1;
        repeat (20) cycle();

        // drop enable at y=1 and let the frame drain to IDLE
        run_until("reach_y1b", 0, 1);
        en_i = 1'b0;
        for (int i = 0; i < 100 && m_state != 0; i++) cycle();
        chk("reach_idle", 32'(m_state), 32'(0));
        repeat (10) cycle();

        // async reset mid-line while x_o shows 2, with underflow set earlier in the line
        en_i = 1'b1;
        starve_on = 1'b1; starve_h = 1; starve_v = 0;
        run_until("reach_x2", 3, 0);
        chk("pre_rst_uf", 32'(underflow_o), 32'(1));
        #3;
        rst = 1'b0;
        #1;
        chk_reset_vals("async");
        starve_on = 1'b0;
        m_state = 0; m_h = 0; m_v = 0; m_uf = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_vals("held");
        rst = 1'b1;
        repeat (60) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_timing_tx.md
VIDEO_TIMING_TX -- requirements
Module: video_timing_tx

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch
- H_SYNC, 40, horizontal sync width
- H_BP, 220, horizontal back porch
- V_ACTIVE, 720, active lines
- V_FP, 5, vertical front porch
- V_SYNC, 5, vertical sync width
- V_BP, 20, vertical back porch
- HS_POL, 1, asserted hs_o level
- VS_POL, 1, asserted vs_o level

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- en_i  in  1  run request
- rgb_i  in  24  source pixel, {R,G,B} in bits [23:16],[15:8],[7:0]
- rgb_valid_i  in  1  source pixel available
- rgb_ready_o  out  1  pixel consumed this cycle
- rgb_o  out  24  output pixel
- dv_o  out  1  data valid
- hs_o  out  1  horizontal sync
- vs_o  out  1  vertical sync
- x_o  out  12  pixel column
- y_o  out  12  pixel row
- frame_start_o  out  1  first-pixel pulse
- underflow_o  out  1  sticky source-starved flag
- underflow_clr_i  in  1  clears underflow_o

REQ-003 The design SHALL use one clock (clk); rst SHALL be asynchronous and active-low.

Function
REQ-004 h_cnt SHALL run 0..H_TOTAL-1, where H_TOTAL = sum of the H_* parameters; the regions SHALL be, in order: active [0,H_ACTIVE), FP, SYNC, BP.
REQ-005 v_cnt SHALL increment when h_cnt wraps and SHALL wrap at V_TOTAL-1; the region order SHALL match REQ-004.
REQ-006 Controller states SHALL be IDLE, RUN and DRAIN.
- IDLE->RUN: en_i=1 sampled; counters start at h=0, v=0.
- RUN->DRAIN: en_i=0 sampled.
- DRAIN->RUN: en_i=1 sampled before the frame end.
- DRAIN->IDLE: at h=H_TOTAL-1, v=V_TOTAL-1.
- In IDLE, counters SHALL be held at 0.
REQ-007 rgb_ready_o SHALL be combinational: 1 only when state is not IDLE, h is active and v is active; the source SHALL pop on rgb_ready_o & rgb_valid_i.
REQ-008 Every output except rgb_ready_o SHALL be registered, with exactly 1 cycle of latency from the counter value.
REQ-009 Output values SHALL be:
- dv_o = h active & v active
- hs_o = HS_POL during the h SYNC region, ~HS_POL otherwise
- vs_o = VS_POL for the whole V SYNC lines, ~VS_POL otherwise
REQ-010 rgb_o SHALL equal rgb_i when the pixel was consumed, and 24'h0 when dv_o=0 or on a starved cycle.
REQ-011 A starved cycle (rgb_ready_o=1, rgb_valid_i=0) SHALL set underflow_o on the next cycle; timing SHALL NOT stall.
REQ-012 underflow_o SHALL be cleared by underflow_clr_i; if a clear and a set occur in the same cycle, the set SHALL win.
REQ-013 x_o and y_o SHALL equal h_cnt and v_cnt, aligned with dv_o, and SHALL be 0 when dv_o=0.
REQ-014 frame_start_o SHALL be a one-cycle pulse coincident with dv_o for x=0, y=0.
REQ-015 In IDLE, dv_o and frame_start_o SHALL be 0, hs_o and vs_o inactive, and rgb_o 0.
REQ-016 Counter widths SHALL be 12 bits; H_TOTAL and V_TOTAL SHALL each be at most 4096 (elaboration-time assertion).

Reset
REQ-017 While rst=0: state IDLE, counters 0, dv_o=0, frame_start_o=0, underflow_o=0, rgb_o=0, x_o=y_o=0, hs_o=~HS_POL, vs_o=~VS_POL.
REQ-018 Reset asserted mid-frame SHALL force the REQ-017 values immediately (asynchronously); after release the block SHALL restart only on en_i.

Structure
REQ-019 Package video_pkg SHALL hold the rgb_t 24-bit typedef, the region enum (ACTIVE, FP, SYNC, BP), the controller state enum and the 12-bit coordinate typedef.
REQ-020 Sub-module timing_counter (parameterised ACTIVE/FP/SYNC/BP, inc input, outputs count, region and wrap) SHALL be instantiated once for horizontal and once for vertical.

Verification
Bench parameters: H 4/1/2/1 (H_TOTAL 8), V 3/1/1/1 (V_TOTAL 6), 48-cycle frame.
REQ-021 en_i=1, source always valid with incrementing data -> per line 4 dv_o cycles with x_o 0..3 and rgb_o equal to the popped values; hs_o high 2 cycles at h 5,6 (+1 latency); vs_o high for line 4; frame_start_o every 48 cycles.
REQ-022 rgb_valid_i=0 at x=2, y=0 -> rgb_o=0 on that pixel, underflow_o=1 from the next cycle until an underflow_clr_i pulse, timing unchanged.
REQ-023 en_i dropped at y=1 -> frame completes through v=5, h=7, then IDLE; rgb_ready_o=0 and outputs at inactive levels thereafter.
REQ-024 HS_POL=0, VS_POL=0 -> hs_o and vs_o are 1 during reset and in IDLE, and 0 only in the sync regions.
REQ-025 rst driven low mid-line at x=2 -> outputs at REQ-017 values without a clock edge; after release with en_i=1 -> restart at x=0, y=0 with a frame_start_o pulse.
